// File: rtl/brq_pkg.sv
// Shared branch-prediction types: direction values, entry fields and
// 2-bit saturating counter encodings.
package brq_pkg;

  localparam logic TAKEN     = 1'b1;
  localparam logic NOT_TAKEN = 1'b0;

  localparam int BRQ_IDX_W  = 6;
  localparam int BRQ_PRED_W = 1;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer of in-flight branch entries with pointer/count
// tracking and a flush that drops everything younger than the head.
module brq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_nxt;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // a push may take the slot freed by a same-cycle pop
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign rd_nxt  = rd_ptr + PW'(pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (push_ok) mem[wr_ptr] <= wdata;
      if (flush) begin
        wr_ptr <= rd_nxt;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push_ok);
        if (push_ok && !pop_ok)
          count <= count + CNT_W'(1);
        else if (pop_ok && !push_ok)
          count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Pops resolved branches in order, emits a registered counter-table update
// and mispredict flush. Optional counters under BRQ_STATS_EN.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BRQ_IDX_W,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_pred,
  output logic             full,
  input  logic             resolve,
  input  logic             resolve_taken,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             err_underflow
`ifdef BRQ_STATS_EN
  ,
  output logic [15:0]      stat_resolved,
  output logic [15:0]      stat_mispred
`endif
);

  localparam int EW = IDX_W + BRQ_PRED_W;

  logic [EW-1:0]    head;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic             res_ok;
  logic             miss;

  assign head_idx  = head[EW-1:1];
  assign head_pred = head[0];
  assign res_ok    = resolve && !empty;
  assign miss      = res_ok && (head_pred != resolve_taken);

  brq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({push_idx, push_pred}),
    .pop   (resolve),
    .flush (miss),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_en        <= 1'b0;
      upd_idx       <= '0;
      upd_taken     <= NOT_TAKEN;
      mispredict    <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      upd_en     <= res_ok;
      mispredict <= miss;
      if (res_ok) begin
        upd_idx   <= head_idx;
        upd_taken <= resolve_taken;
      end
      if (resolve && empty) err_underflow <= 1'b1;
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (res_ok && stat_resolved != 16'hFFFF)
        stat_resolved <= stat_resolved + 16'd1;
      if (miss && stat_mispred != 16'hFFFF)
        stat_mispred <= stat_mispred + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue; define BRQ_STATS_EN
// to also exercise the statistics counters.
module tb_branch_resolve_queue;
  import brq_pkg::*;

  localparam int DEPTH = 4;
  localparam int IDX_W = 6;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push = 1'b0;
  logic [IDX_W-1:0] push_idx = '0;
  logic             push_pred = 1'b0;
  logic             full;
  logic             resolve = 1'b0;
  logic             resolve_taken = 1'b0;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             mispredict;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             err_underflow;
`ifdef BRQ_STATS_EN
  logic [15:0]      stat_resolved;
  logic [15:0]      stat_mispred;
`endif

  branch_resolve_queue #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .push_idx      (push_idx),
    .push_pred     (push_pred),
    .full          (full),
    .resolve       (resolve),
    .resolve_taken (resolve_taken),
    .upd_en        (upd_en),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .mispredict    (mispredict),
    .empty         (empty),
    .count         (count),
    .err_underflow (err_underflow)
`ifdef BRQ_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } ent_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             taken;
    logic             mis;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  logic m_err = 1'b0;
  int   m_res = 0;
  int   m_mis = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_err = 1'b0;
    m_res = 0;
    m_mis = 0;
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("err", 32'(err_underflow), 32'(m_err));
`ifdef BRQ_STATS_EN
    chk("st_res", 32'(stat_resolved), 32'(m_res));
    chk("st_mis", 32'(stat_mispred), 32'(m_mis));
`endif
  endtask

  // one clock: drive, step model, check outputs #1 after the edge
  task automatic cyc(input logic p, input logic [IDX_W-1:0] pi,
                     input logic pp, input logic r, input logic rt,
                     input bit full_chk = 1'b1);
    bit   rok;
    bit   miss;
    bit   pok;
    ent_t e;
    exp_t x;
    push = p;
    push_idx = pi;
    push_pred = pp;
    resolve = r;
    resolve_taken = rt;
    rok = r && mq.size() > 0;
    miss = 1'b0;
    if (rok) begin
      e = mq[0];
      miss = (e.pred != rt);
      x.idx = e.idx;
      x.taken = rt;
      x.mis = miss;
      sb.push_back(x);
    end
    if (r && mq.size() == 0) m_err = 1'b1;
    pok = p && (mq.size() < DEPTH || rok) && !miss;
    @(posedge clk);
    #1;
    if (rok) begin
      void'(mq.pop_front());
      if (m_res < 65535) m_res++;
    end
    if (miss) begin
      mq.delete();
      if (m_mis < 65535) m_mis++;
    end
    if (pok) begin
      e.idx = pi;
      e.pred = pp;
      mq.push_back(e);
    end
    if (full_chk) chk("upd_en", 32'(upd_en), 32'(rok));
    if (upd_en) begin
      if (sb.size() == 0) begin
        chk("sb_spur", 32'(upd_en), 32'(0));
      end else begin
        x = sb.pop_front();
        chk("upd_idx", 32'(upd_idx), 32'(x.idx));
        chk("upd_tkn", 32'(upd_taken), 32'(x.taken));
        chk("mispred", 32'(mispredict), 32'(x.mis));
      end
    end else if (full_chk) begin
      chk("mis_idle", 32'(mispredict), 32'(0));
    end
    if (full_chk) check_state();
    push = 1'b0;
    resolve = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cnt"}, 32'(count), 32'(0));
    chk({tag, "_emp"}, 32'(empty), 32'(1));
    chk({tag, "_full"}, 32'(full), 32'(0));
    chk({tag, "_upd"}, 32'(upd_en), 32'(0));
    chk({tag, "_uidx"}, 32'(upd_idx), 32'(0));
    chk({tag, "_utkn"}, 32'(upd_taken), 32'(0));
    chk({tag, "_mis"}, 32'(mispredict), 32'(0));
    chk({tag, "_err"}, 32'(err_underflow), 32'(0));
  endtask

  initial begin
    do_reset();
    check_reset_vals("rst");

    // single correct prediction, resolved two cycles after push
    cyc(1, 6'd5, TAKEN, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, TAKEN);
    chk("t1_idx", 32'(upd_idx), 32'(5));
    chk("t1_mis", 32'(mispredict), 32'(0));
    cyc(0, 0, 0, 0, 0);

    // mispredict flushes younger entries and the same-cycle push
    cyc(1, 6'd1, NOT_TAKEN, 0, 0);
    cyc(1, 6'd2, NOT_TAKEN, 0, 0);
    cyc(1, 6'd3, NOT_TAKEN, 0, 0);
    cyc(1, 6'd9, TAKEN, 1, TAKEN);
    chk("t2_mis", 32'(mispredict), 32'(1));
    chk("t2_idx", 32'(upd_idx), 32'(1));
    chk("t2_cnt", 32'(count), 32'(0));
    cyc(0, 0, 0, 0, 0);

    // fill, drop while full, push+resolve at full, drain across wrap
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 6'(10 + i), 1'(i % 2), 0, 0);
    chk("t3_full", 32'(full), 32'(1));
    cyc(1, 6'd14, TAKEN, 0, 0);
    chk("t3_drop", 32'(count), 32'(4));
    cyc(1, 6'd15, TAKEN, 1, NOT_TAKEN);
    chk("t3_keep", 32'(count), 32'(4));
    cyc(0, 0, 0, 1, TAKEN);
    cyc(0, 0, 0, 1, NOT_TAKEN);
    cyc(0, 0, 0, 1, TAKEN);
    cyc(0, 0, 0, 1, TAKEN);
    chk("t3_last", 32'(upd_idx), 32'(15));
    chk("t3_emp", 32'(empty), 32'(1));

    // mixed traffic with correct predictions only
    for (int i = 0; i < 40; i++) begin
      logic p, pp, r, rt;
      p = 1'($urandom_range(0, 1));
      pp = 1'($urandom_range(0, 1));
      r = (mq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rt = (mq.size() > 0) ? mq[0].pred : 1'b0;
      cyc(p, 6'($urandom_range(0, 63)), pp, r, rt);
    end
    while (mq.size() > 0) cyc(0, 0, 0, 1, mq[0].pred);

    // mixed traffic including mispredicts
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)),
          (mq.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
          1'($urandom_range(0, 1)));
    end
    while (mq.size() > 0) cyc(0, 0, 0, 1, mq[0].pred);

    // underflow is ignored but sticky
    cyc(0, 0, 0, 1, TAKEN);
    chk("t4_err", 32'(err_underflow), 32'(1));
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("t4_hold", 32'(err_underflow), 32'(1));

    // asynchronous reset mid-queue
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 6'(20 + i), TAKEN, 0, 0);
    cyc(0, 0, 0, 1, TAKEN);
    chk("t5_pre", 32'(count), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    cyc(0, 0, 0, 1, TAKEN);
    chk("t5_err", 32'(err_underflow), 32'(1));

`ifdef BRQ_STATS_EN
    do_reset();
    cyc(1, 6'd1, TAKEN, 0, 0);
    cyc(1, 6'd2, TAKEN, 0, 0);
    cyc(1, 6'd3, TAKEN, 0, 0);
    cyc(0, 0, 0, 1, TAKEN);
    cyc(0, 0, 0, 1, TAKEN);
    cyc(0, 0, 0, 1, NOT_TAKEN);
    chk("t6_res", 32'(stat_resolved), 32'(3));
    chk("t6_mis", 32'(stat_mispred), 32'(1));
    cyc(1, 6'd7, TAKEN, 0, 0);
    for (int i = 0; i < 65540; i++)
      cyc(1, 6'(i), TAKEN, 1, TAKEN, (i > 65520));
    chk("t6_sat", 32'(stat_resolved), 32'(16'hFFFF));
    cyc(0, 0, 0, 1, NOT_TAKEN);
    chk("t6_sat2", 32'(stat_resolved), 32'(16'hFFFF));
`endif

    chk("sb_left", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
